// File: rtl/drac_pkg.sv
// Shared types and defaults for the L1.5 request arbiter.
package drac_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  localparam int unsigned DefaultStarveTh = 16;

endpackage

// File: rtl/l15_arb_prio_sel.sv
// One-hot rotating priority selector: first set request at or after start_i wins.
module l15_arb_prio_sel #(
  parameter int unsigned N    = 6,
  parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] start_i,
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] idx_o
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [IdxW:0]  sum;
  logic           found;

  // Rotating the doubled vector puts the start port at bit 0.
  assign dbl = {req_i, req_i} >> start_i;
  assign rot = dbl[N-1:0];

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    idx_o = '0;
    gnt_o = '0;
    sum   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        sum   = {1'b0, start_i} + (IdxW+1)'(i);
        if (sum >= (IdxW+1)'(N)) sum = sum - (IdxW+1)'(N);
        idx_o = sum[IdxW-1:0];
        gnt_o = N'(1) << sum[IdxW-1:0];
      end
    end
  end

endmodule

// File: rtl/l15_req_arbiter.sv
// N-port request arbiter feeding the single registered L1.5 request channel,
// with fixed or round-robin order plus per-port anti-starvation aging.
module l15_req_arbiter
  import drac_pkg::*;
#(
  parameter int unsigned NumPorts     = 6,
  parameter int unsigned PayloadWidth = 128,
  parameter arb_mode_e   ArbMode      = ARB_FIXED,
  parameter int unsigned StarveTh     = DefaultStarveTh,
  parameter int unsigned PortIdWidth  = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             arb_en_i,
  input  logic [NumPorts-1:0]              req_valid_i,
  output logic [NumPorts-1:0]              req_ready_o,
  input  logic [NumPorts*PayloadWidth-1:0] req_data_i,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic [PayloadWidth-1:0]          out_data_o,
  output logic [PortIdWidth-1:0]           out_portid_o,
  output logic                             starve_event_o
);

  localparam int unsigned    CntW = (StarveTh > 0) ? $clog2(StarveTh + 1) : 1;
  localparam logic [CntW-1:0] ThC = CntW'(StarveTh);

  logic [CntW-1:0]         cnt_q [NumPorts];
  logic [PayloadWidth-1:0] payload [NumPorts];
  logic [PortIdWidth-1:0]  ptr_q, rr_start, norm_start, urg_idx, norm_idx, gidx;
  logic [NumPorts-1:0]     eligible, urgent, urg_req, urg_gnt, norm_gnt, gnt;
  logic [NumPorts-1:0]     inc, hit_pre;
  logic                    slot_free, accept;

  for (genvar p = 0; p < NumPorts; p++) begin : g_payload
    assign payload[p] = req_data_i[p*PayloadWidth +: PayloadWidth];
  end

  assign slot_free = ~out_valid_o | out_ready_i;
  assign eligible  = req_valid_i & {NumPorts{arb_en_i & slot_free}};

  always_comb begin
    urgent  = '0;
    inc     = '0;
    hit_pre = '0;
    for (int unsigned p = 0; p < NumPorts; p++) begin
      urgent[p]  = (StarveTh > 0) && (cnt_q[p] == ThC);
      inc[p]     = accept && req_valid_i[p] && !gnt[p];
      hit_pre[p] = (StarveTh > 0) && inc[p] && (cnt_q[p] == ThC - CntW'(1));
    end
  end

  assign urg_req    = eligible & urgent;
  assign rr_start   = (ptr_q == PortIdWidth'(NumPorts - 1)) ? '0 : ptr_q + 1'b1;
  assign norm_start = (ArbMode == ARB_RR) ? rr_start : '0;

  l15_arb_prio_sel #(.N(NumPorts), .IdxW(PortIdWidth)) u_sel_urgent (
    .req_i   (urg_req),
    .start_i ('0),
    .gnt_o   (urg_gnt),
    .idx_o   (urg_idx)
  );

  l15_arb_prio_sel #(.N(NumPorts), .IdxW(PortIdWidth)) u_sel_normal (
    .req_i   (eligible),
    .start_i (norm_start),
    .gnt_o   (norm_gnt),
    .idx_o   (norm_idx)
  );

  assign gnt         = (|urg_req) ? urg_gnt : norm_gnt;
  assign gidx        = (|urg_req) ? urg_idx : norm_idx;
  assign req_ready_o = rst_ni ? gnt : '0;
  // gnt is a subset of req_valid_i, so any ready bit is an accept.
  assign accept      = |req_ready_o;

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_ni) begin
      out_valid_o    <= 1'b0;
      out_data_o     <= '0;
      out_portid_o   <= '0;
      starve_event_o <= 1'b0;
      ptr_q          <= PortIdWidth'(NumPorts - 1);
    end else begin
      starve_event_o <= |hit_pre;
      if (accept) begin
        out_valid_o  <= 1'b1;
        out_data_o   <= payload[gidx];
        out_portid_o <= gidx;
        if (ArbMode == ARB_RR) ptr_q <= gidx;
      end else if (out_ready_i) begin
        out_valid_o <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: the aging array is real control state, so every entry is reset (unlike a data RAM).
    if (!rst_ni) begin
      for (int unsigned p = 0; p < NumPorts; p++) cnt_q[p] <= '0;
    end else begin
      for (int unsigned p = 0; p < NumPorts; p++) begin
        if (StarveTh == 0 || !req_valid_i[p] || req_ready_o[p]) cnt_q[p] <= '0;
        else if (inc[p] && cnt_q[p] != ThC) cnt_q[p] <= cnt_q[p] + CntW'(1);
      end
    end
  end

endmodule

// File: tb/tb_l15_req_arbiter.sv
// Directed bench: a fixed-priority instance (StarveTh=4) and a round-robin instance.
module tb_l15_req_arbiter;
  import drac_pkg::*;

  localparam int unsigned NP = 6;
  localparam int unsigned PW = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic            f_en, f_oready, f_ovalid, f_starve;
  logic [NP-1:0]   f_valid, f_ready;
  logic [NP*PW-1:0] f_data;
  logic [PW-1:0]   f_odata;
  logic [2:0]      f_pid;

  logic            r_en, r_oready, r_ovalid, r_starve;
  logic [NP-1:0]   r_valid, r_ready;
  logic [NP*PW-1:0] r_data;
  logic [PW-1:0]   r_odata;
  logic [2:0]      r_pid;

  int checks   = 0;
  int failures = 0;

  l15_req_arbiter #(.NumPorts(NP), .PayloadWidth(PW), .ArbMode(ARB_FIXED), .StarveTh(4)) u_fix (
    .clk_i(clk), .rst_ni(rst_n), .arb_en_i(f_en), .req_valid_i(f_valid), .req_ready_o(f_ready),
    .req_data_i(f_data), .out_valid_o(f_ovalid), .out_ready_i(f_oready), .out_data_o(f_odata),
    .out_portid_o(f_pid), .starve_event_o(f_starve)
  );

  l15_req_arbiter #(.NumPorts(NP), .PayloadWidth(PW), .ArbMode(ARB_RR), .StarveTh(16)) u_rr (
    .clk_i(clk), .rst_ni(rst_n), .arb_en_i(r_en), .req_valid_i(r_valid), .req_ready_o(r_ready),
    .req_data_i(r_data), .out_valid_o(r_ovalid), .out_ready_i(r_oready), .out_data_o(r_odata),
    .out_portid_o(r_pid), .starve_event_o(r_starve)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    f_en = 1'b1; r_en = 1'b1; f_oready = 1'b1; r_oready = 1'b1;
    f_valid = '0; r_valid = '0;
    for (int p = 0; p < NP; p++) begin
      f_data[p*PW +: PW] = 16'hA000 + 16'(p);
      r_data[p*PW +: PW] = 16'hB000 + 16'(p);
    end

    // Reset: ready forced low even with all valids high
    tick(); tick();
    f_valid = 6'h3F; r_valid = 6'h3F; #1;
    chk("rst_f_ready", 32'(f_ready), 32'h0);
    chk("rst_r_ready", 32'(r_ready), 32'h0);
    chk("rst_f_ovalid", 32'(f_ovalid), 32'h0);
    chk("rst_f_pid", 32'(f_pid), 32'h0);
    chk("rst_f_starve", 32'(f_starve), 32'h0);
    chk("rst_r_odata", 32'(r_odata), 32'h0);
    f_valid = '0; r_valid = '0;
    tick();
    rst_n = 1'b1;

    // Fixed priority, ports 1,3,5 drained in order
    f_valid = 6'b101010; #1;
    chk("t1_ready0", 32'(f_ready), 32'h02);
    chk("t1_ovalid0", 32'(f_ovalid), 32'h0);
    tick(); f_valid = 6'b101000; #1;
    chk("t1_ovalid1", 32'(f_ovalid), 32'h1);
    chk("t1_pid1", 32'(f_pid), 32'h1);
    chk("t1_data1", 32'(f_odata), 32'hA001);
    chk("t1_ready1", 32'(f_ready), 32'h08);
    tick(); f_valid = 6'b100000; #1;
    chk("t1_pid3", 32'(f_pid), 32'h3);
    chk("t1_data3", 32'(f_odata), 32'hA003);
    chk("t1_ready3", 32'(f_ready), 32'h20);
    tick(); f_valid = '0; #1;
    chk("t1_pid5", 32'(f_pid), 32'h5);
    chk("t1_data5", 32'(f_odata), 32'hA005);
    chk("t1_ready5", 32'(f_ready), 32'h0);
    tick(); #1;
    chk("t1_drain", 32'(f_ovalid), 32'h0);
    chk("t1_pid_hold", 32'(f_pid), 32'h5);

    // Aging: port 2 loses four times to port 0, then wins once
    f_valid = 6'b000101; #1;
    chk("t3_ready0", 32'(f_ready), 32'h01);
    for (int k = 1; k <= 3; k++) begin
      tick(); #1;
      chk("t3_pid0", 32'(f_pid), 32'h0);
      chk("t3_ready_p0", 32'(f_ready), 32'h01);
      chk("t3_no_starve", 32'(f_starve), 32'h0);
    end
    tick(); #1;
    chk("t3_starve", 32'(f_starve), 32'h1);
    chk("t3_urgent_ready", 32'(f_ready), 32'h04);
    tick(); #1;
    chk("t3_pid2", 32'(f_pid), 32'h2);
    chk("t3_data2", 32'(f_odata), 32'hA002);
    chk("t3_ready_back", 32'(f_ready), 32'h01);
    chk("t3_starve_pulse", 32'(f_starve), 32'h0);
    tick(); #1;
    chk("t3_resume", 32'(f_pid), 32'h0);
    f_valid = '0;
    tick();

    // Output stall: nothing moves, aging frozen
    f_valid = 6'b000110; #1;
    chk("t4_ready0", 32'(f_ready), 32'h02);
    tick(); f_oready = 1'b0; #1;
    chk("t4_pid1", 32'(f_pid), 32'h1);
    chk("t4_ready_stall", 32'(f_ready), 32'h0);
    for (int k = 0; k < 10; k++) begin
      tick(); #1;
      chk("t4_stall_ready", 32'(f_ready), 32'h0);
      chk("t4_stall_valid", 32'(f_ovalid), 32'h1);
      chk("t4_stall_pid", 32'(f_pid), 32'h1);
      chk("t4_stall_data", 32'(f_odata), 32'hA001);
    end
    f_oready = 1'b1; #1;
    chk("t4_release_ready", 32'(f_ready), 32'h02);
    tick(); #1;
    chk("t4_refill_valid", 32'(f_ovalid), 32'h1);
    chk("t4_refill_pid", 32'(f_pid), 32'h1);
    chk("t4_e1_starve", 32'(f_starve), 32'h0);
    tick(); #1;
    chk("t4_e2_starve", 32'(f_starve), 32'h0);
    tick(); #1;
    chk("t4_e3_starve", 32'(f_starve), 32'h1);
    chk("t4_e3_ready", 32'(f_ready), 32'h04);
    tick(); #1;
    chk("t4_e4_pid", 32'(f_pid), 32'h2);
    f_valid = '0;
    tick();

    // arb_en low: held output drains, no new grant
    f_valid = 6'b000001; #1;
    chk("t5_ready0", 32'(f_ready), 32'h01);
    tick(); f_en = 1'b0; #1;
    chk("t5_held", 32'(f_ovalid), 32'h1);
    chk("t5_held_pid", 32'(f_pid), 32'h0);
    chk("t5_ready_off", 32'(f_ready), 32'h0);
    tick(); #1;
    chk("t5_drained", 32'(f_ovalid), 32'h0);
    chk("t5_ready_still_off", 32'(f_ready), 32'h0);
    tick(); #1;
    chk("t5_stay_empty", 32'(f_ovalid), 32'h0);
    f_en = 1'b1; #1;
    chk("t5_ready_on", 32'(f_ready), 32'h01);
    tick(); #1;
    chk("t5_regrant", 32'(f_ovalid), 32'h1);
    f_valid = '0;
    tick();

    // Round robin with all ports valid
    r_valid = 6'h3F; #1;
    chk("t2_ready0", 32'(r_ready), 32'h01);
    for (int k = 0; k < 8; k++) begin
      tick(); #1;
      chk("t2_valid", 32'(r_ovalid), 32'h1);
      chk("t2_pid", 32'(r_pid), 32'(k % 6));
      chk("t2_data", 32'(r_odata), 32'hB000 + 32'(k % 6));
      chk("t2_ready", 32'(r_ready), 32'h1 << ((k + 1) % 6));
    end

    // Reset mid-transfer
    rst_n = 1'b0; f_valid = 6'h01; #1;
    chk("t6_r_ready_rst", 32'(r_ready), 32'h0);
    chk("t6_f_ready_rst", 32'(f_ready), 32'h0);
    chk("t6_held_before", 32'(r_ovalid), 32'h1);
    tick(); #1;
    chk("t6_ovalid", 32'(r_ovalid), 32'h0);
    chk("t6_pid", 32'(r_pid), 32'h0);
    chk("t6_starve", 32'(r_starve), 32'h0);
    chk("t6_data", 32'(r_odata), 32'h0);
    rst_n = 1'b1; f_valid = '0; #1;
    chk("t6_rr_restart", 32'(r_ready), 32'h01);
    tick(); #1;
    chk("t6_rr_pid0", 32'(r_pid), 32'h0);
    chk("t6_rr_valid", 32'(r_ovalid), 32'h1);
    r_valid = '0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/l15_req_arbiter.md
Name: l15_req_arbiter

Overview:
Parametrised N-port request arbiter that merges the I$/D$ miss, writeback, uncached and AMO request streams into the single L1.5 request channel of the tile wrapper. It generalises the fixed six-port, fixed-priority port ordering to any port count and payload width. It adds a selectable round-robin mode, per-port anti-starvation aging, and a registered output stage with full throughput.

Parameters:
NumPorts, 6, number of request ports; port 0 has highest static priority.
PayloadWidth, 128, width of each port's request payload in bits.
ArbMode, ARB_FIXED, ARB_FIXED = lowest index wins; ARB_RR = round-robin.
StarveTh, 16, number of lost accept cycles before a port becomes urgent; 0 disables aging.
PortIdWidth, (NumPorts>1 ? $clog2(NumPorts) : 1), derived; must not be overridden.

Ports:
clk_i  in  1  clock, the only clock of the block.
rst_ni  in  1  reset; synchronous, active-low.
arb_en_i  in  1  when 0, no new grant is issued; the held output still drains.
req_valid_i  in  NumPorts  per-port request valid.
req_ready_o  out  NumPorts  per-port accept, one-hot or zero.
req_data_i  in  NumPorts*PayloadWidth  payloads; port p occupies bits [p*PayloadWidth +: PayloadWidth].
out_valid_o  out  1  output register holds a request.
out_ready_i  in  1  L1.5 side accepts the output.
out_data_o  out  PayloadWidth  registered payload.
out_portid_o  out  PortIdWidth  source port of out_data_o.
starve_event_o  out  1  one-cycle pulse when any port's aging counter reaches StarveTh.

Behaviour:
- Reset (rst_ni=0 at a clock edge): out_valid_o=0, out_data_o=0, out_portid_o=0, starve_event_o=0, all aging counters 0, RR pointer = NumPorts-1 (so port 0 is first in RR order). req_ready_o is forced to 0 while rst_ni=0. A reset mid-transfer discards the held request with no response.
- slot_free = ~out_valid_o | out_ready_i.
- Grant: computed combinationally each cycle from eligible = req_valid_i & {NumPorts{arb_en_i & slot_free}}. There is no lock, so a valid that drops before acceptance is simply not granted. req_ready_o[g]=1 only for the granted port g.
- Selection order:
  - Urgent eligible ports (counter == StarveTh, StarveTh>0) beat non-urgent ones; among urgent ports the lowest index wins.
  - Otherwise ARB_FIXED picks the lowest index.
  - ARB_RR picks the first eligible port searching ptr+1, ptr+2, … modulo NumPorts.
- Accept = req_valid_i[g] & req_ready_o[g]. On the next edge: out_data_o <= port g payload, out_portid_o <= g, out_valid_o <= 1, and RR pointer <= g (RR mode only).
- Output drain: out_valid_o & out_ready_i with no new accept sets out_valid_o <= 0. Data and portid hold their last values when not loaded.
- Latency: request to out_valid_o is 1 cycle. Throughput is 1 request per cycle when out_ready_i stays high. Drain and refill happen in the same cycle.
- Aging counters, width $clog2(StarveTh+1), one per port:
  - +1 on a cycle where an accept occurs for another port while this port is valid.
  - Saturates at StarveTh.
  - Clears to 0 when this port is accepted or when its req_valid_i=0.
  - Unchanged on cycles with no accept (stall or arb_en_i=0).
- starve_event_o = 1 for the cycle after any counter transitions from StarveTh-1 to StarveTh.
- StarveTh=0: counters are constant 0, no urgency, starve_event_o stays 0.
- NumPorts=1: the grant is req_valid_i[0] gated by arb_en_i and slot_free; out_portid_o stays 0.
- out_ready_i low while full: all req_ready_o=0 and the output holds stable (valid/data/portid must not change).

Decomposition:
- drac_pkg: arb_mode_e {ARB_FIXED, ARB_RR} enum and the default StarveTh constant.
- Sub-module l15_arb_prio_sel: parametrised one-hot rotating priority selector. Inputs are a request vector and a start index; outputs are a one-hot grant and an encoded index. It is instantiated twice: once for urgent ports with start 0, once for normal ports with start 0 or ptr+1. The top level muxes between the two results.

Test Plan:
1. After reset release, ARB_FIXED, ports 1,3,5 valid with distinct data, out_ready_i=1 → outputs leave in order 1,3,5, one per cycle; first out_valid_o is one cycle after the first accept.
2. ARB_RR, all 6 ports valid continuously → out_portid_o sequence is 0,1,2,3,4,5,0,…, with no gaps.
3. ARB_FIXED, StarveTh=4, ports 0 and 2 always valid → port 2 counter reaches 4 after four port-0 accepts; starve_event_o pulses once; port 2 wins the next grant, then port 0 resumes.
4. Output full, out_ready_i=0 for 10 cycles with ports valid → req_ready_o=0 throughout, out_data_o/out_portid_o stable, counters unchanged; on out_ready_i=1 the drain and a new accept occur in the same cycle.
5. arb_en_i=0 with one request held → held output drains and out_valid_o falls to 0; no new grant until arb_en_i=1.
6. Assert rst_ni=0 while out_valid_o=1 → next edge out_valid_o=0, out_portid_o=0, starve_event_o=0, req_ready_o=0 during reset; RR restarts at port 0.
